// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and constants for the sha256 front-end
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        SEND,
        WAIT
    } padder_state_t;

    localparam int         BLK_BYTES = 64;
    localparam int         LEN_OFS   = 56;
    localparam logic [7:0] PAD_MARK  = 8'h80;

endpackage

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - byte stream to padded 512-bit SHA-256 blocks
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic [7:0]   data_i,
    input  logic         data_vld_i,
    input  logic         data_last_i,
    output logic         data_rdy_o,
    output logic [511:0] blk_o,
    output logic         blk_vld_o,
    output logic         blk_first_o,
    output logic         blk_last_o,
    input  logic         blk_done_i,
    output logic         msg_done_o,
    output logic         busy_o
);

    padder_state_t state_q, state_d;

    logic [7:0]       blk_buf [BLK_BYTES];
    logic [5:0]       idx_q;
    logic [LEN_W-4:0] len_q;
    logic             one_done_q, first_q, open_q;
    logic             rdy_q, vld_q, first_o_q, last_o_q, msg_done_q;

    logic             accept, send_last, last_idx, len_slot;
    logic [LEN_W-1:0] bit_len;

    assign accept   = data_vld_i & rdy_q;
    assign last_idx = (idx_q == 6'(BLK_BYTES - 1));
    assign len_slot = one_done_q && (idx_q == 6'(LEN_OFS));
    // Byte count times eight; wraps naturally at LEN_W bits.
    assign bit_len  = {len_q, 3'b000};

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        send_last = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = data_last_i ? PAD : FILL;
            FILL: if (accept) begin
                if (last_idx)         state_d = SEND;
                else if (data_last_i) state_d = PAD;
            end
            PAD: begin
                if (len_slot) begin
                    state_d   = SEND;
                    send_last = 1'b1;
                end else if (last_idx) begin
                    state_d = SEND;
                end
            end
            SEND: state_d = WAIT;
            WAIT: if (blk_done_i) state_d = last_o_q ? IDLE : (open_q ? FILL : PAD);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < BLK_BYTES; k++) blk_buf[k] <= 8'h00;
            idx_q      <= '0;
            len_q      <= '0;
            one_done_q <= 1'b0;
            first_q    <= 1'b0;
            open_q     <= 1'b0;
            rdy_q      <= 1'b0;
            vld_q      <= 1'b0;
            first_o_q  <= 1'b0;
            last_o_q   <= 1'b0;
            msg_done_q <= 1'b0;
        end else begin
            // Ready is registered from the next state so it drops with reset.
            rdy_q      <= (state_d == IDLE) || (state_d == FILL);
            vld_q      <= (state_d == SEND);
            msg_done_q <= 1'b0;
            if (state_d == SEND) begin
                first_o_q <= first_q;
                last_o_q  <= send_last;
            end
            case (state_q)
                IDLE: if (accept) begin
                    blk_buf[0] <= data_i;
                    idx_q      <= 6'd1;
                    len_q      <= (LEN_W-3)'(1);
                    first_q    <= 1'b1;
                    one_done_q <= 1'b0;
                    open_q     <= ~data_last_i;
                end
                FILL: if (accept) begin
                    blk_buf[idx_q] <= data_i;
                    idx_q          <= idx_q + 6'd1;
                    len_q          <= len_q + (LEN_W-3)'(1);
                    if (data_last_i) open_q <= 1'b0;
                end
                PAD: begin
                    if (len_slot) begin
                        for (int k = 0; k < 8; k++)
                            blk_buf[LEN_OFS + k] <= bit_len[8*(7-k) +: 8];
                    end else begin
                        blk_buf[idx_q] <= one_done_q ? 8'h00 : PAD_MARK;
                        one_done_q     <= 1'b1;
                        idx_q          <= idx_q + 6'd1;
                    end
                end
                WAIT: if (blk_done_i) begin
                    first_q    <= 1'b0;
                    idx_q      <= '0;
                    msg_done_q <= last_o_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        blk_o = '0;
        for (int b = 0; b < BLK_BYTES; b++)
            blk_o[32*(b/4) + 8*(3 - (b%4)) +: 8] = blk_buf[b];
    end

    assign data_rdy_o  = rdy_q;
    assign blk_vld_o   = vld_q;
    assign blk_first_o = first_o_q;
    assign blk_last_o  = last_o_q;
    assign msg_done_o  = msg_done_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - self-checking bench for sha256_padder
module tb_sha256_padder;

    typedef logic [7:0] u8;

    logic         clk = 1'b0;
    logic         rstn_i, data_vld_i, data_last_i, blk_done_i;
    logic [7:0]   data_i;
    logic         data_rdy_o, blk_vld_o, blk_first_o, blk_last_o, msg_done_o, busy_o;
    logic [511:0] blk_o;

    int chk = 0;
    int pass = 0;
    int done_cnt = 0;
    int resp_extra = 0;
    int resp_d;

    logic [511:0] got_blk[$];
    logic         got_first[$], got_last[$];

    always #5 clk = ~clk;

    sha256_padder #(.LEN_W(64)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .data_i(data_i), .data_vld_i(data_vld_i),
        .data_last_i(data_last_i), .data_rdy_o(data_rdy_o), .blk_o(blk_o),
        .blk_vld_o(blk_vld_o), .blk_first_o(blk_first_o), .blk_last_o(blk_last_o),
        .blk_done_i(blk_done_i), .msg_done_o(msg_done_o), .busy_o(busy_o)
    );

    always @(negedge clk) begin
        if (blk_vld_o) begin
            got_blk.push_back(blk_o);
            got_first.push_back(blk_first_o);
            got_last.push_back(blk_last_o);
        end
        if (msg_done_o) done_cnt++;
    end

    // Compressor stand-in: pulses done a few cycles after each block.
    always begin
        @(negedge clk);
        if (blk_vld_o && rstn_i) begin
            resp_d = $urandom_range(1, 4) + resp_extra;
            repeat (resp_d - 1) @(negedge clk);
            @(negedge clk);
            blk_done_i = 1'b1;
            @(negedge clk);
            blk_done_i = 1'b0;
        end
    end

    // Reference padding: marker, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic build_exp(input u8 m[$], output logic [511:0] e[$]);
        u8           p[$];
        logic [63:0] bl;
        logic [511:0] blk;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
        e.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int w = 0; w < 16; w++)
                blk[32*w +: 32] = {p[64*b+4*w], p[64*b+4*w+1], p[64*b+4*w+2], p[64*b+4*w+3]};
            e.push_back(blk);
        end
    endtask

    task automatic clear_obs();
        got_blk.delete();
        got_first.delete();
        got_last.delete();
        done_cnt = 0;
    endtask

    task automatic send_bytes(input u8 m[$], input bit gaps);
        int i = 0;
        int g = 0;
        while (i < m.size() && g < 5000) begin
            @(negedge clk);
            g++;
            data_vld_i  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            data_i      = m[i];
            data_last_i = (i == m.size() - 1);
            if (data_vld_i && data_rdy_o) i++;
        end
        @(negedge clk);
        data_vld_i  = 1'b0;
        data_last_i = 1'b0;
        chk++;
        if (i != m.size()) $display("FAIL send_timeout sent %0d need %0d", i, m.size());
        else pass++;
    endtask

    task automatic wait_done(input int budget);
        int g = 0;
        while (done_cnt == 0 && g < budget) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk++;
        if (done_cnt == 0) $display("FAIL msg_done_timeout got 0 pulses need 1");
        else pass++;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; data_vld_i = 1'b0; data_last_i = 1'b0; data_i = 8'h00; blk_done_i = 1'b0;
        repeat (3) @(negedge clk);
        chk++;
        if ({data_rdy_o, blk_vld_o, blk_first_o, blk_last_o, msg_done_o, busy_o} !== 6'b0 || blk_o !== '0)
            $display("FAIL reset_outputs got rdy%b vld%b busy%b blk %h need all 0", data_rdy_o, blk_vld_o, busy_o, blk_o);
        else pass++;
        rstn_i = 1'b1;
        @(negedge clk);
        chk++;
        if (data_rdy_o !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL reset_idle got rdy %b busy %b need 1 0", data_rdy_o, busy_o);
        else pass++;
    endtask

    task automatic test_abc();
        u8 m[$] = '{8'h61, 8'h62, 8'h63};
        logic [511:0] e[$];
        clear_obs();
        build_exp(m, e);
        send_bytes(m, 1'b0);
        wait_done(500);
        chk++;
        if (got_blk.size() !== 1 || got_first[0] !== 1'b1 || got_last[0] !== 1'b1)
            $display("FAIL abc_flags got n%0d f%b l%b need n1 f1 l1", got_blk.size(), got_first[0], got_last[0]);
        else pass++;
        chk++;
        if (got_blk[0][31:0] !== 32'h61626380 || got_blk[0][479:32] !== '0 || got_blk[0][511:480] !== 32'h18)
            $display("FAIL abc_block got %h need 61626380..00000018", got_blk[0]);
        else pass++;
        chk++;
        if (got_blk[0] !== e[0]) $display("FAIL abc_model got %h need %h", got_blk[0], e[0]);
        else pass++;
        chk++;
        if (done_cnt !== 1) $display("FAIL abc_done got %0d need 1", done_cnt);
        else pass++;
    endtask

    task automatic test_boundaries();
        int lens[3] = '{55, 56, 64};
        for (int t = 0; t < 3; t++) begin
            u8 m[$];
            logic [511:0] e[$];
            m.delete();
            for (int i = 0; i < lens[t]; i++) m.push_back(lens[t] == 64 ? u8'(i) : 8'h00);
            clear_obs();
            build_exp(m, e);
            send_bytes(m, 1'b0);
            wait_done(1000);
            chk++;
            if (got_blk.size() !== e.size())
                $display("FAIL bnd%0d_nblk got %0d need %0d", lens[t], got_blk.size(), e.size());
            else pass++;
            for (int b = 0; b < e.size() && b < got_blk.size(); b++) begin
                chk++;
                if (got_blk[b] !== e[b] || got_first[b] !== (b == 0) || got_last[b] !== (b == e.size() - 1))
                    $display("FAIL bnd%0d_blk%0d got %h f%b l%b need %h", lens[t], b, got_blk[b], got_first[b], got_last[b], e[b]);
                else pass++;
            end
            chk++;
            case (lens[t])
                55: if (got_blk[0][13*32 +: 8] !== 8'h80 || got_blk[0][511:480] !== 32'h1B8)
                        $display("FAIL bnd55_const got %h need byte55 80 word15 1B8", got_blk[0]);
                    else pass++;
                56: if (got_blk[0][14*32+24 +: 8] !== 8'h80 || got_blk[1][511:480] !== 32'h1C0)
                        $display("FAIL bnd56_const got %h %h need marker@56 and 1C0", got_blk[0], got_blk[1]);
                    else pass++;
                default: if (got_blk[0][31:0] !== 32'h00010203 || got_blk[1][31:0] !== 32'h80000000 || got_blk[1][511:480] !== 32'h200)
                        $display("FAIL bnd64_const got %h %h need 00010203 / 80000000..200", got_blk[0], got_blk[1]);
                    else pass++;
            endcase
            chk++;
            if (done_cnt !== 1) $display("FAIL bnd%0d_done got %0d need 1", lens[t], done_cnt);
            else pass++;
        end
    endtask

    task automatic test_random(input bit gaps, input int n_msgs);
        for (int t = 0; t < n_msgs; t++) begin
            u8 m[$];
            logic [511:0] e[$];
            int len;
            m.delete();
            len = (t == 0) ? 3 : $urandom_range(1, 200);
            for (int i = 0; i < len; i++) m.push_back((t == 0) ? u8'(8'h61 + i) : u8'($urandom));
            clear_obs();
            build_exp(m, e);
            send_bytes(m, gaps);
            wait_done(2000);
            chk++;
            if (got_blk.size() !== e.size())
                $display("FAIL rnd%0d_len%0d_nblk got %0d need %0d", t, len, got_blk.size(), e.size());
            else pass++;
            for (int b = 0; b < e.size() && b < got_blk.size(); b++) begin
                chk++;
                if (got_blk[b] !== e[b] || got_first[b] !== (b == 0) || got_last[b] !== (b == e.size() - 1))
                    $display("FAIL rnd%0d_blk%0d got %h f%b l%b need %h", t, b, got_blk[b], got_first[b], got_last[b], e[b]);
                else pass++;
            end
            chk++;
            if (done_cnt !== 1) $display("FAIL rnd%0d_done got %0d need 1", t, done_cnt);
            else pass++;
        end
    endtask

    task automatic test_stall();
        u8 m[$] = '{8'h61, 8'h62, 8'h63};
        logic [511:0] held;
        int bad = 0;
        int g = 0;
        clear_obs();
        resp_extra = 100;
        fork
            begin
                send_bytes(m, 1'b0);
                wait_done(1000);
            end
            begin
                do begin
                    @(negedge clk);
                    g++;
                end while (!blk_vld_o && g < 1000);
                held = blk_o;
                repeat (100) begin
                    @(negedge clk);
                    if (blk_o !== held || data_rdy_o !== 1'b0 || blk_vld_o !== 1'b0 || busy_o !== 1'b1) bad++;
                end
            end
        join
        resp_extra = 0;
        chk++;
        if (bad !== 0) $display("FAIL stall_hold got %0d unstable cycles need 0", bad);
        else pass++;
        chk++;
        if (got_blk.size() !== 1 || done_cnt !== 1)
            $display("FAIL stall_pulses got vld %0d done %0d need 1 1", got_blk.size(), done_cnt);
        else pass++;
    endtask

    task automatic test_reset_mid_pad();
        u8 m[$] = '{8'h61, 8'h62, 8'h63};
        logic [511:0] e[$];
        clear_obs();
        send_bytes(m, 1'b0);
        rstn_i = 1'b0;
        @(negedge clk);
        chk++;
        if ({data_rdy_o, blk_vld_o, blk_first_o, blk_last_o, msg_done_o, busy_o} !== 6'b0 || blk_o !== '0)
            $display("FAIL midpad_reset got rdy%b vld%b busy%b blk %h need all 0", data_rdy_o, blk_vld_o, busy_o, blk_o);
        else pass++;
        rstn_i = 1'b1;
        repeat (2) @(negedge clk);
        clear_obs();
        build_exp(m, e);
        send_bytes(m, 1'b0);
        wait_done(500);
        chk++;
        if (got_blk.size() !== 1 || got_blk[0] !== e[0] || got_first[0] !== 1'b1 || got_last[0] !== 1'b1 || done_cnt !== 1)
            $display("FAIL midpad_rerun got n%0d %h need %h", got_blk.size(), got_blk[0], e[0]);
        else pass++;
    endtask

    initial begin
        test_reset();
        test_abc();
        test_boundaries();
        test_random(1'b1, 5);
        test_random(1'b0, 6);
        test_stall();
        test_reset_mid_pad();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
